// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch (IF) and load/store (LSU).
// Define ARB_FETCH_FAIR_EN to force an IF win after MAX_WAIT consecutive contested losses.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,

    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic                if_gnt_o,
    output logic                if_rvalid_o,
    output logic [DATA_W-1:0]   if_rdata_o,
    output logic                if_stall_o,

    input  logic                lsu_req_i,
    input  logic                lsu_we_i,
    input  logic [ADDR_W-1:0]   lsu_addr_i,
    input  logic [DATA_W-1:0]   lsu_wdata_i,
    input  logic [DATA_W/8-1:0] lsu_be_i,
    output logic                lsu_gnt_o,
    output logic                lsu_rvalid_o,
    output logic [DATA_W-1:0]   lsu_rdata_o,
    output logic                lsu_stall_o,

    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i
);

    typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

    state_e              state_q, state_d;
    logic                owner_lsu_q, owner_lsu_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W/8-1:0] be_q, be_d;

    logic resp;
    logic arb_en;
    logic any_req;
    logic pick_lsu;
    logic busy;

    if (MAX_WAIT == 0) begin : gen_bad_max_wait
        $error("MAX_WAIT must be at least 1");
    end

    assign resp    = (state_q == StWait) && mem_rvalid_i;
    // A response cycle doubles as an arbitration slot so back-to-back requests see no bubble.
    assign arb_en  = (state_q == StIdle) || resp;
    assign any_req = if_req_i || lsu_req_i;

`ifdef ARB_FETCH_FAIR_EN
    localparam int unsigned CntW = $clog2(MAX_WAIT + 1);

    logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
    logic            force_if;

    assign force_if = (wait_cnt_q == CntW'(MAX_WAIT));

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        pick_lsu   = lsu_req_i;
        if (arb_en) begin
            if (lsu_req_i && if_req_i) begin
                if (force_if) begin
                    pick_lsu   = 1'b0;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + CntW'(1);
                end
            end else if (if_req_i) begin
                wait_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    assign pick_lsu = lsu_req_i;
`endif

    always_comb begin
        state_d     = state_q;
        owner_lsu_d = owner_lsu_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        be_d        = be_q;

        case (state_q)
            StReq:   if (mem_gnt_i) state_d = StWait;
            StWait:  if (mem_rvalid_i) state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (arb_en && any_req) begin
            state_d     = StReq;
            owner_lsu_d = pick_lsu;
            if (pick_lsu) begin
                addr_d  = lsu_addr_i;
                we_d    = lsu_we_i;
                wdata_d = lsu_wdata_i;
                be_d    = lsu_be_i;
            end else begin
                addr_d  = if_addr_i;
                we_d    = 1'b0;
                wdata_d = '0;
                be_d    = '1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            owner_lsu_q <= 1'b0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            be_q        <= '0;
        end else begin
            state_q     <= state_d;
            owner_lsu_q <= owner_lsu_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
        end
    end

    assign mem_req_o   = (state_q == StReq);
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign mem_be_o    = be_q;

    assign if_gnt_o     = mem_req_o && mem_gnt_i && !owner_lsu_q;
    assign lsu_gnt_o    = mem_req_o && mem_gnt_i && owner_lsu_q;
    assign if_rvalid_o  = resp && !owner_lsu_q;
    assign lsu_rvalid_o = resp && owner_lsu_q;
    assign if_rdata_o   = mem_rdata_i;
    assign lsu_rdata_o  = mem_rdata_i;

    // Outstanding covers both the latched-not-granted and granted-not-answered phases.
    assign busy        = (state_q != StIdle);
    assign if_stall_o  = (if_req_i || (busy && !owner_lsu_q)) && !if_rvalid_o;
    assign lsu_stall_o = (lsu_req_i || (busy && owner_lsu_q)) && !lsu_rvalid_o;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random traffic checked
// against a transaction-level model of the arbitration and memory handshake rules.
module tb_mem_port_arbiter;

    logic        clk_i;
    logic        rst_ni;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid, if_stall;
    logic [31:0] if_rdata;
    logic        lsu_req, lsu_we;
    logic [31:0] lsu_addr, lsu_wdata;
    logic [3:0]  lsu_be;
    logic        lsu_gnt, lsu_rvalid, lsu_stall;
    logic [31:0] lsu_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    // Model: per-side pending request and the single transaction on the memory port.
    bit          if_pend, lsu_pend;
    logic [31:0] if_a, l_a, l_wd;
    bit          l_we;
    logic [3:0]  l_be;
    bit          t_open, t_busy, t_lsu;
    logic [31:0] t_addr, t_wd;
    bit          t_we;
    logic [3:0]  t_be;
    int          streak;
    int          if_gnts, lsu_gnts;

    mem_port_arbiter dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .if_req_i     (if_req),
        .if_addr_i    (if_addr),
        .if_gnt_o     (if_gnt),
        .if_rvalid_o  (if_rvalid),
        .if_rdata_o   (if_rdata),
        .if_stall_o   (if_stall),
        .lsu_req_i    (lsu_req),
        .lsu_we_i     (lsu_we),
        .lsu_addr_i   (lsu_addr),
        .lsu_wdata_i  (lsu_wdata),
        .lsu_be_i     (lsu_be),
        .lsu_gnt_o    (lsu_gnt),
        .lsu_rvalid_o (lsu_rvalid),
        .lsu_rdata_o  (lsu_rdata),
        .lsu_stall_o  (lsu_stall),
        .mem_req_o    (mem_req),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_be_o     (mem_be),
        .mem_gnt_i    (mem_gnt),
        .mem_rvalid_i (mem_rvalid),
        .mem_rdata_i  (mem_rdata)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic apply_reset(input string tag);
        @(negedge clk_i);
        rst_ni = 1'b0;
        if_req = 1'b0; if_addr = '0;
        lsu_req = 1'b0; lsu_we = 1'b0; lsu_addr = '0; lsu_wdata = '0; lsu_be = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = '0;
        #1;
        chk1({tag, "_mem_req"}, mem_req, 1'b0);
        chk1({tag, "_mem_we"}, mem_we, 1'b0);
        chk32({tag, "_mem_addr"}, mem_addr, 32'h0);
        chk32({tag, "_mem_wdata"}, mem_wdata, 32'h0);
        chk32({tag, "_mem_be"}, 32'(mem_be), 32'h0);
        chk1({tag, "_if_gnt"}, if_gnt, 1'b0);
        chk1({tag, "_if_rvalid"}, if_rvalid, 1'b0);
        chk1({tag, "_if_stall"}, if_stall, 1'b0);
        chk1({tag, "_lsu_gnt"}, lsu_gnt, 1'b0);
        chk1({tag, "_lsu_rvalid"}, lsu_rvalid, 1'b0);
        chk1({tag, "_lsu_stall"}, lsu_stall, 1'b0);
        chk32({tag, "_if_rdata"}, if_rdata, 32'h0);
        chk32({tag, "_lsu_rdata"}, lsu_rdata, 32'h0);
        if_pend = 0; lsu_pend = 0; t_open = 0; t_busy = 0; t_lsu = 0; streak = 0;
        repeat (2) @(negedge clk_i);
        mem_rvalid = 1'b0;
        rst_ni = 1'b1;
    endtask

    // One clock cycle: optionally raise new requests, drive memory handshake, check, advance.
    task automatic step(input bit s_if, input logic [31:0] ia,
                        input bit s_lsu, input bit lwe, input logic [31:0] la,
                        input logic [31:0] lwd, input logic [3:0] lbe,
                        input bit gnt, input bit rv, input logic [31:0] rd);
        bit   resp, arb, lsu_wins;
        logic e_if_gnt, e_lsu_gnt, e_if_rv, e_lsu_rv;
        @(negedge clk_i);
        if (s_if && !if_pend) begin
            if_pend = 1; if_a = ia;
        end
        if (s_lsu && !lsu_pend) begin
            lsu_pend = 1; l_we = lwe; l_a = la; l_wd = lwd; l_be = lbe;
        end
        if_req = if_pend; if_addr = if_a;
        lsu_req = lsu_pend; lsu_we = l_we; lsu_addr = l_a; lsu_wdata = l_wd; lsu_be = l_be;
        mem_gnt = gnt && t_open;
        mem_rvalid = rv;
        mem_rdata = rd;
        #1;
        e_if_gnt  = t_open && gnt && !t_lsu;
        e_lsu_gnt = t_open && gnt && t_lsu;
        e_if_rv   = t_busy && rv && !t_lsu;
        e_lsu_rv  = t_busy && rv && t_lsu;
        chk1("mem_req", mem_req, t_open);
        if (t_open) begin
            chk32("mem_addr", mem_addr, t_addr);
            chk1("mem_we", mem_we, t_we);
            chk32("mem_be", 32'(mem_be), 32'(t_be));
            if (t_we) chk32("mem_wdata", mem_wdata, t_wd);
        end
        chk1("if_gnt", if_gnt, e_if_gnt);
        chk1("lsu_gnt", lsu_gnt, e_lsu_gnt);
        chk1("if_rvalid", if_rvalid, e_if_rv);
        chk1("lsu_rvalid", lsu_rvalid, e_lsu_rv);
        chk32("if_rdata", if_rdata, rd);
        chk32("lsu_rdata", lsu_rdata, rd);
        chk1("if_stall", if_stall, (if_pend || ((t_open || t_busy) && !t_lsu)) && !e_if_rv);
        chk1("lsu_stall", lsu_stall, (lsu_pend || ((t_open || t_busy) && t_lsu)) && !e_lsu_rv);
        if (if_gnt) if_gnts++;
        if (lsu_gnt) lsu_gnts++;

        resp = t_busy && rv;
        arb  = (!t_open && !t_busy) || resp;
        if (t_open && gnt) begin
            t_open = 0; t_busy = 1;
            if (t_lsu) lsu_pend = 0; else if_pend = 0;
        end else if (resp) begin
            t_busy = 0;
        end
        if (arb && (if_pend || lsu_pend)) begin
            lsu_wins = lsu_pend;
`ifdef ARB_FETCH_FAIR_EN
            if (if_pend && lsu_pend) begin
                if (streak == 4) begin
                    lsu_wins = 0; streak = 0;
                end else begin
                    streak++;
                end
            end else if (if_pend) begin
                streak = 0;
            end
`endif
            t_open = 1; t_lsu = lsu_wins;
            if (lsu_wins) begin
                t_addr = l_a; t_we = l_we; t_wd = l_wd; t_be = l_be;
            end else begin
                t_addr = if_a; t_we = 0; t_wd = '0; t_be = 4'hF;
            end
        end
    endtask

    task automatic idle_step(input bit gnt, input bit rv, input logic [31:0] rd);
        step(0, '0, 0, 0, '0, '0, '0, gnt, rv, rd);
    endtask

    initial begin
        rst_ni = 1'b0;
        if_req = 1'b0; lsu_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        if_pend = 0; lsu_pend = 0; t_open = 0; t_busy = 0; streak = 0;
        apply_reset("reset");

        // Single fetch with immediate grant and one-cycle response.
        step(1, 32'h100, 0, 0, '0, '0, '0, 0, 0, '0);
        chk1("fetch_stall_req", if_stall, 1'b1);
        idle_step(1, 0, '0);
        chk32("fetch_addr", mem_addr, 32'h100);
        chk1("fetch_we", mem_we, 1'b0);
        chk1("fetch_gnt", if_gnt, 1'b1);
        idle_step(0, 1, 32'h0050_0093);
        chk1("fetch_rvalid", if_rvalid, 1'b1);
        chk32("fetch_rdata", if_rdata, 32'h0050_0093);
        chk1("fetch_stall_drop", if_stall, 1'b0);

        // Store with grant held off for three cycles.
        if_gnts = 0; lsu_gnts = 0;
        step(0, '0, 1, 1, 32'h2000, 32'hDEAD_BEEF, 4'b0011, 0, 0, '0);
        repeat (3) begin
            idle_step(0, 0, '0);
            chk1("store_req_held", mem_req, 1'b1);
            chk32("store_wdata", mem_wdata, 32'hDEAD_BEEF);
        end
        idle_step(1, 0, '0);
        chk32("store_be", 32'(mem_be), 32'h3);
        idle_step(0, 1, 32'h0);
        chk1("store_ack", lsu_rvalid, 1'b1);
        chk32("store_lsu_gnts", lsu_gnts, 32'd1);
        chk32("store_if_gnts", if_gnts, 32'd0);

        // Contention: LSU first, IF back-to-back.
        step(1, 32'h104, 1, 0, 32'h3000, '0, 4'hF, 0, 0, '0);
        idle_step(1, 0, '0);
        chk32("cont_lsu_addr", mem_addr, 32'h3000);
        chk1("cont_lsu_gnt", lsu_gnt, 1'b1);
        idle_step(0, 1, 32'h1111_2222);
        chk1("cont_lsu_rvalid", lsu_rvalid, 1'b1);
        chk1("cont_if_stall", if_stall, 1'b1);
        idle_step(1, 0, '0);
        chk1("cont_b2b_req", mem_req, 1'b1);
        chk32("cont_if_addr", mem_addr, 32'h104);
        chk1("cont_if_gnt", if_gnt, 1'b1);
        idle_step(0, 1, 32'h3333_4444);
        chk1("cont_if_rvalid", if_rvalid, 1'b1);
        chk1("cont_if_stall_drop", if_stall, 1'b0);

        // Reset while waiting for a response; the stale response must be ignored.
        step(0, '0, 1, 0, 32'h40, '0, 4'hF, 0, 0, '0);
        idle_step(1, 0, '0);
        idle_step(0, 0, '0);
        apply_reset("midrst");
        idle_step(0, 1, 32'hBAD0_BAD0);
        chk1("stale_lsu_rvalid", lsu_rvalid, 1'b0);
        step(1, 32'h200, 0, 0, '0, '0, '0, 0, 0, '0);
        idle_step(1, 0, '0);
        chk32("post_rst_addr", mem_addr, 32'h200);
        idle_step(0, 1, 32'h1234_5678);
        chk1("post_rst_rvalid", if_rvalid, 1'b1);

        // Both sides request continuously; 20 transactions complete in 40 cycles.
        apply_reset("fair");
        if_gnts = 0; lsu_gnts = 0;
        repeat (40) begin
            step(1, $urandom & 32'hFFFF_FFFC, 1, 1'($urandom), $urandom & 32'hFFFF_FFFC,
                 $urandom, 4'($urandom), 1, 1, $urandom);
        end
`ifdef ARB_FETCH_FAIR_EN
        chk32("fair_if_gnts", if_gnts, 32'd4);
        chk32("fair_lsu_gnts", lsu_gnts, 32'd16);
`else
        chk32("fair_if_gnts", if_gnts, 32'd0);
        chk32("fair_lsu_gnts", lsu_gnts, 32'd20);
`endif

        // Random traffic, including spurious rvalid outside the wait phase.
        repeat (400) begin
            step($urandom_range(0, 2) == 0, $urandom & 32'hFFFF_FFFC,
                 $urandom_range(0, 2) == 0, 1'($urandom), $urandom & 32'hFFFF_FFFC,
                 $urandom, 4'($urandom), 1'($urandom), 1'($urandom), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates a single-port unified instruction/data memory between the fetch stage (IF) and the load/store path of the MEM stage (LSU) in the 5-stage pipeline. Requests are sequenced one at a time through a request/grant/response protocol, and per-side stall signals are returned to the hazard logic. The LSU request is formed from the decoder's `mem_rden_o | mem_wren_o`, and `lsu_we_i` is driven from `mem_wren_o`.

## Interface
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width.
- `MAX_WAIT`, 4, consecutive IF losses before IF is forced to win. Used only when `ARB_FETCH_FAIR_EN` is defined.

Clock and reset:
- `clk_i` in, 1: the single clock.
- `rst_ni` in, 1: reset, asynchronous, active-low.

IF port:
- `if_req_i` in, 1: fetch request. Held until `if_gnt_o`.
- `if_addr_i` in, `ADDR_W`: fetch address.
- `if_gnt_o` out, 1: fetch request accepted by memory.
- `if_rvalid_o` out, 1: fetch data valid.
- `if_rdata_o` out, `DATA_W`: fetch data.
- `if_stall_o` out, 1: fetch stage must stall.

LSU port:
- `lsu_req_i` in, 1: load/store request. Held until `lsu_gnt_o`.
- `lsu_we_i` in, 1: 1 = store.
- `lsu_addr_i` in, `ADDR_W`: load/store address.
- `lsu_wdata_i` in, `DATA_W`: store data.
- `lsu_be_i` in, `DATA_W/8`: byte enables.
- `lsu_gnt_o` out, 1: load/store request accepted by memory.
- `lsu_rvalid_o` out, 1: load data valid or store acknowledged.
- `lsu_rdata_o` out, `DATA_W`: load data.
- `lsu_stall_o` out, 1: MEM stage must stall.

Memory port:
- `mem_req_o` out, 1: request to memory.
- `mem_we_o` out, 1: write enable.
- `mem_addr_o` out, `ADDR_W`: address.
- `mem_wdata_o` out, `DATA_W`: write data.
- `mem_be_o` out, `DATA_W/8`: byte enables.
- `mem_gnt_i` in, 1: memory accepts the request.
- `mem_rvalid_i` in, 1: one response per granted request, read or write.
- `mem_rdata_i` in, `DATA_W`: read data.

## Operation
- FSM states:
  - IDLE: no transaction in flight.
  - REQ: `mem_req_o` = 1, waiting for `mem_gnt_i`.
  - WAIT: granted, waiting for `mem_rvalid_i`.
- At most one transaction is outstanding.
- Arbitration runs in IDLE, and in WAIT in the cycle `mem_rvalid_i` = 1.
  - If any request is pending: latch the owner (IF or LSU) plus addr, we, wdata and be into registers, then go to REQ.
  - Otherwise go to IDLE.
- Priority: LSU wins when both request, because the MEM stage is the older instruction.
- IF transactions drive `mem_we_o` = 0 and `mem_be_o` = all ones.
- REQ: the `mem_*` outputs come from the latched registers. On `mem_gnt_i`, assert the owner's `*_gnt_o` combinationally in that cycle, then go to WAIT.
- WAIT: on `mem_rvalid_i`, assert the owner's `*_rvalid_o` combinationally and pass `mem_rdata_i` through to that owner's `*_rdata_o`.
- The non-owner's gnt and rvalid stay 0. Both `*_rdata_o` outputs show `mem_rdata_i` at all times; the data is qualified only by rvalid.
- `mem_rvalid_i` in IDLE or REQ is ignored.
- Stall outputs, with "outstanding" meaning latched or in flight for that side:
  - `if_stall_o` = (`if_req_i` | IF outstanding) & ~`if_rvalid_o`.
  - `lsu_stall_o` is the same expression using the LSU signals.
- Reset: asserting `rst_ni` at any time, including mid-transaction, forces IDLE immediately.
  - All outputs go to 0.
  - Latched fields and the wait counter are cleared.
  - A response to a transaction aborted by reset arrives in IDLE and is ignored.

## Timing
- Requests are registered: a request seen in IDLE at cycle N gives `mem_req_o` = 1 at cycle N+1.
- `mem_gnt_i` at N+1 gives `*_gnt_o` at N+1 and enters WAIT at N+2.
- Minimum response latency: `mem_rvalid_i` at N+2 gives `*_rvalid_o` at N+2.
- Back-to-back: if rvalid and a new pending request coincide at cycle M, `mem_req_o` = 1 at M+1 with no IDLE bubble.
- `mem_req_o` and the latched fields stay stable from REQ entry until `mem_gnt_i`.

## Configuration
- `ARB_FETCH_FAIR_EN` defined:
  - A saturating counter, `$clog2(MAX_WAIT+1)` bits, increments on each arbitration where both sides request and LSU wins.
  - When the counter equals `MAX_WAIT`, the next contested arbitration goes to IF and clears the counter.
  - Any IF win also clears the counter.
- `ARB_FETCH_FAIR_EN` undefined: strict LSU priority, and no counter is instantiated.

## Test plan
- Single fetch:
  - Stimulus: `if_req_i`=1, `if_addr_i`=0x100, memory grants immediately and responds 1 cycle later with 0x00500093.
  - Required: `mem_addr_o`=0x100, `mem_we_o`=0, `if_rvalid_o`=1 with `if_rdata_o`=0x00500093, `if_stall_o` drops in the rvalid cycle.
- Store:
  - Stimulus: `lsu_req_i`=1, `lsu_we_i`=1, addr 0x2000, wdata 0xDEADBEEF, be 0b0011, gnt delayed 3 cycles.
  - Required: `mem_req_o` held for 4 cycles with fields stable, `lsu_gnt_o` pulses once, `lsu_rvalid_o` on ack, `if_gnt_o` never asserts.
- Contention:
  - Stimulus: IF and LSU request in the same cycle.
  - Required: LSU is served first; IF is served back-to-back with `mem_req_o` high the cycle after LSU rvalid; `if_stall_o`=1 throughout.
- Fairness (`ARB_FETCH_FAIR_EN`, `MAX_WAIT`=4):
  - Stimulus: LSU requests continuously and IF requests continuously.
  - Required: 4 LSU transactions, then 1 IF transaction, repeating. With the macro undefined, IF is never granted.
- Reset mid-transaction:
  - Stimulus: deassert `rst_ni` while in WAIT, release it, then the stale `mem_rvalid_i` arrives.
  - Required: all outputs 0 during reset, no `*_rvalid_o` from the stale response, and the next request proceeds normally.
